// File: rtl/computie_bus_pkg.sv
// Shared definitions for the computie bus trace loader and dumper:
// FSM encodings, ASCII framing characters and packed-record field offsets.
package computie_bus_pkg;

    localparam logic [2:0] ST_LINE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_SKIP = 3'd4;

    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    // Record layout is {mode, addr, data}, data in the low bits.
    localparam int REC_DATA_LSB = 0;

    function automatic int rec_addr_lsb(input int bitwidth);
        return bitwidth;
    endfunction

    function automatic int rec_mode_lsb(input int bitwidth);
        return 2 * bitwidth;
    endfunction

endpackage

// File: rtl/computie_bus_hex_decode.sv
// Combinational ASCII hex digit decoder: byte -> {valid, nibble}.
// Lowercase 'a'-'f' accepted only when COMPUTIE_BUS_LOADER_LOWERCASE_EN is defined.
module computie_bus_hex_decode (
    input  logic [7:0] ch,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            valid  = 1'b1;
            nibble = 4'(ch - 8'h30);
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            valid  = 1'b1;
            nibble = 4'(ch - 8'h37);
        end
`ifdef COMPUTIE_BUS_LOADER_LOWERCASE_EN
        else if (ch >= 8'h61 && ch <= 8'h66) begin
            valid  = 1'b1;
            nibble = 4'(ch - 8'h57);
        end
`endif
    end

endmodule

// File: rtl/computie_bus_loader.sv
// Rebuilds packed bus records from the computie trace text stream (R/W<addr>:<data>\n).
// Optional lowercase hex via COMPUTIE_BUS_LOADER_LOWERCASE_EN (see computie_bus_hex_decode).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_LINE | start of line: expect R/W, blank line closes a block
// ST_ADDR | collecting address hex digits until ':'
// ST_DATA | collecting data hex digits until '\n'
// ST_EMIT | record presented, input stalled until consumer handshake
// ST_SKIP | discarding the rest of a malformed line
module computie_bus_loader
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int MODWIDTH = 1,
    parameter int DEPTH    = 512
) (
    input  logic                           comm_clock,
    input  logic                           comm_reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    output logic                           record_out_valid,
    input  logic                           record_out_ready,
    output logic [BITWIDTH*2+MODWIDTH-1:0] record_out,
    output logic [$clog2(DEPTH):0]         record_out_index,
    output logic [$clog2(DEPTH):0]         record_count,
    output logic                           load_end,
    output logic                           parse_error,
    output logic                           led
);

    localparam int DIGITS   = BITWIDTH / 4;
    localparam int DCW      = $clog2(DIGITS) + 1;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int RW       = BITWIDTH * 2 + MODWIDTH;
    localparam int ADDR_LSB = rec_addr_lsb(BITWIDTH);
    localparam int MODE_LSB = rec_mode_lsb(BITWIDTH);

    logic [2:0]          state_q;
    logic                ready_en_q;
    logic                mode_q;
    logic [BITWIDTH-1:0] addr_q;
    logic [BITWIDTH-1:0] data_q;
    logic [DCW-1:0]      digits_q;
    logic [CW-1:0]       count_q;
    logic [RW-1:0]       record_q;
    logic                valid_q;
    logic                load_end_q;
    logic                parse_error_q;
    logic                led_q;

    logic                hex_valid;
    logic [3:0]          hex_nibble;
    logic                take;
    logic                is_cr;
    logic                is_lf;
    logic                digits_full;
    logic [DCW-1:0]      digits_inc;
    logic [RW-1:0]       next_record;

    computie_bus_hex_decode u_hex (
        .ch     (in_data),
        .valid  (hex_valid),
        .nibble (hex_nibble)
    );

    assign take        = in_valid && in_ready;
    assign is_cr       = (in_data == CH_CR);
    assign is_lf       = (in_data == CH_LF);
    assign digits_full = (digits_q == DCW'(DIGITS));
    assign digits_inc  = (digits_q == {DCW{1'b1}}) ? digits_q : digits_q + 1'b1;

    always_comb begin
        next_record = '0;
        next_record[REC_DATA_LSB +: BITWIDTH] = data_q;
        next_record[ADDR_LSB +: BITWIDTH]     = addr_q;
        next_record[MODE_LSB]                 = mode_q;
    end

    // ready_en_q holds in_ready low for the first cycle out of reset.
    assign in_ready         = ready_en_q && (state_q != ST_EMIT);
    assign record_out_valid = valid_q;
    assign record_out       = record_q;
    assign record_out_index = count_q;
    assign record_count     = count_q;
    assign load_end         = load_end_q;
    assign parse_error      = parse_error_q;
    assign led              = led_q;

    always_ff @(posedge comm_clock or negedge comm_reset_n) begin
        if (!comm_reset_n) begin
            state_q       <= ST_LINE;
            ready_en_q    <= 1'b0;
            mode_q        <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            digits_q      <= '0;
            count_q       <= '0;
            record_q      <= '0;
            valid_q       <= 1'b0;
            load_end_q    <= 1'b0;
            parse_error_q <= 1'b0;
            led_q         <= 1'b0;
        end else begin
            ready_en_q    <= 1'b1;
            load_end_q    <= 1'b0;
            parse_error_q <= 1'b0;
            case (state_q)
                ST_LINE: begin
                    if (take && !is_cr) begin
                        if (in_data == CH_R || in_data == CH_W) begin
                            mode_q   <= (in_data == CH_R);
                            addr_q   <= '0;
                            data_q   <= '0;
                            digits_q <= '0;
                            state_q  <= ST_ADDR;
                        end else if (is_lf) begin
                            if (count_q != '0) begin
                                load_end_q <= 1'b1;
                                count_q    <= '0;
                            end
                        end else begin
                            parse_error_q <= 1'b1;
                            state_q       <= ST_SKIP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (take && !is_cr) begin
                        if (hex_valid && !digits_full) begin
                            addr_q   <= (addr_q << 4) | BITWIDTH'(hex_nibble);
                            digits_q <= digits_inc;
                        end else if (in_data == CH_COLON && digits_full) begin
                            digits_q <= '0;
                            state_q  <= ST_DATA;
                        end else begin
                            parse_error_q <= 1'b1;
                            state_q       <= is_lf ? ST_LINE : ST_SKIP;
                        end
                    end
                end
                ST_DATA: begin
                    if (take && !is_cr) begin
                        if (hex_valid && !digits_full) begin
                            data_q   <= (data_q << 4) | BITWIDTH'(hex_nibble);
                            digits_q <= digits_inc;
                        end else if (is_lf && digits_full) begin
                            // A full block drops the record; the '\n' is consumed.
                            if (count_q == CW'(DEPTH)) begin
                                parse_error_q <= 1'b1;
                                state_q       <= ST_LINE;
                            end else begin
                                record_q <= next_record;
                                valid_q  <= 1'b1;
                                state_q  <= ST_EMIT;
                            end
                        end else begin
                            parse_error_q <= 1'b1;
                            state_q       <= is_lf ? ST_LINE : ST_SKIP;
                        end
                    end
                end
                ST_EMIT: begin
                    if (valid_q && record_out_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 1'b1;
                        led_q   <= ~led_q;
                        state_q <= ST_LINE;
                    end
                end
                ST_SKIP: begin
                    if (take && is_lf) begin
                        state_q <= ST_LINE;
                    end
                end
                default: begin
                    state_q <= ST_LINE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_computie_bus_loader.sv
// Scoreboard bench for computie_bus_loader: directed text lines, expected records queued
// by the stimulus side and popped by a monitor on each record handshake.
module tb_computie_bus_loader;

    localparam int BW    = 32;
    localparam int MW    = 1;
    localparam int DEPTH = 4;
    localparam int RW    = BW * 2 + MW;
    localparam int IW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [RW-1:0] rec;
        logic [IW-1:0] idx;
    } exp_t;

    logic          comm_clock = 1'b0;
    logic          comm_reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          record_out_valid;
    logic          record_out_ready = 1'b1;
    logic [RW-1:0] record_out;
    logic [IW-1:0] record_out_index;
    logic [IW-1:0] record_count;
    logic          load_end;
    logic          parse_error;
    logic          led;

    int   checks = 0;
    int   errors = 0;
    int   n_load_end = 0;
    int   n_perr = 0;
    exp_t exp_q[$];

    computie_bus_loader #(.BITWIDTH(BW), .MODWIDTH(MW), .DEPTH(DEPTH)) dut (
        .comm_clock       (comm_clock),
        .comm_reset_n     (comm_reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .record_out_valid (record_out_valid),
        .record_out_ready (record_out_ready),
        .record_out       (record_out),
        .record_out_index (record_out_index),
        .record_count     (record_count),
        .load_end         (load_end),
        .parse_error      (parse_error),
        .led              (led)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rec(input logic mode, input logic [31:0] addr, input logic [31:0] data,
                              input int idx);
        exp_t e;
        e.rec = {mode, addr, data};
        e.idx = IW'(idx);
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(negedge comm_clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
        end else begin
            @(posedge comm_clock);
            @(negedge comm_clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge comm_clock);
    endtask

    // Monitor: sample well clear of the rising edge, after stimulus settles.
    always @(negedge comm_clock) begin
        #2;
        if (comm_reset_n) begin
            if (load_end) n_load_end++;
            if (parse_error) n_perr++;
            if (load_end && parse_error) begin
                checks++;
                errors++;
                $display("FAIL pulse_overlap: load_end and parse_error both high");
            end
            if (record_out_valid && record_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_record: got %0h idx %0d expected none",
                             record_out, record_out_index);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (record_out !== e.rec || record_out_index !== e.idx) begin
                        errors++;
                        $display("FAIL record: got %0h idx %0d expected %0h idx %0d",
                                 record_out, record_out_index, e.rec, e.idx);
                    end
                end
            end
        end
    end

    initial begin
        int le0;
        int pe0;

        // Reset values
        idle(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", record_out_valid, 0);
        check("rst_record", record_out, 0);
        check("rst_index", record_out_index, 0);
        check("rst_count", record_count, 0);
        check("rst_flags", {load_end, parse_error, led}, 0);
        comm_reset_n = 1'b1;
        idle(1);
        check("ready_after_reset", in_ready, 1);

        // Two records then a blank line
        expect_rec(1'b1, 32'h00001234, 32'hDEADBEEF, 0);
        expect_rec(1'b0, 32'h0000ABCD, 32'h00000001, 1);
        le0 = n_load_end;
        send_str("\nR00001234:DEADBEEF\nW0000ABCD:00000001\n");
        idle(3);
        check("t1_count", record_count, 2);
        check("t1_led", led, 0);
        check("t1_header_no_load_end", n_load_end - le0, 0);
        send_str("\n");
        idle(3);
        check("t1_load_end", n_load_end - le0, 1);
        check("t1_count_cleared", record_count, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // Back-pressure: record held, input stalled, pending byte survives
        record_out_ready = 1'b0;
        expect_rec(1'b1, 32'h00001234, 32'hDEADBEEF, 0);
        send_str("R00001234:DEADBEEF\n");
        in_valid = 1'b1;
        in_data  = "W";
        for (int i = 0; i < 10; i++) begin
            @(negedge comm_clock);
            check("t2_valid_held", record_out_valid, 1);
            check("t2_record_held", record_out, {1'b1, 32'h00001234, 32'hDEADBEEF});
            check("t2_in_ready_low", in_ready, 0);
        end
        record_out_ready = 1'b1;
        send_byte("W");
        check("t2_led_toggled", led, 1);
        expect_rec(1'b0, 32'h0000ABCD, 32'h00000001, 1);
        send_str("0000ABCD:00000001\n");
        idle(3);
        check("t2_count", record_count, 2);

        // Short address, overlong address, CR tolerance
        pe0 = n_perr;
        send_str("R0001234");
        send_byte(":");
        check("t3_perr_at_colon", parse_error, 1);
        send_str("DEADBEEF\nR12345678");
        send_byte("9");
        check("t3_perr_9th_digit", parse_error, 1);
        send_str(":00000000\n");
        expect_rec(1'b0, 32'h00000010, 32'h00000020, 2);
        send_str("W00000010:00000020\r\n");
        idle(3);
        check("t3_perr_count", n_perr - pe0, 2);
        check("t3_count", record_count, 3);

        // Lowercase hex
`ifdef COMPUTIE_BUS_LOADER_LOWERCASE_EN
        expect_rec(1'b1, 32'hDEADBEEF, 32'h00000000, 3);
        send_str("Rdeadbeef:00000000\n");
        idle(3);
        check("t4_count", record_count, 4);
`else
        send_byte("R");
        send_byte("d");
        check("t4_perr_lowercase", parse_error, 1);
        send_str("eadbeef:00000000\n");
        idle(3);
        check("t4_count", record_count, 3);
`endif
        le0 = n_load_end;
        send_str("\n");
        idle(3);
        check("t4_load_end", n_load_end - le0, 1);
        check("t4_count_cleared", record_count, 0);

        // Block overflow at DEPTH
        for (int i = 0; i < 4; i++) expect_rec(1'b0, 32'(i + 1), 32'(i + 1), i);
        send_str("W00000001:00000001\nW00000002:00000002\n");
        send_str("W00000003:00000003\nW00000004:00000004\n");
        send_str("W00000005:00000005");
        send_byte("\n");
        check("t5_perr_overflow", parse_error, 1);
        idle(3);
        check("t5_count_full", record_count, 4);
        check("t5_queue_empty", exp_q.size(), 0);
        le0 = n_load_end;
        send_str("\n");
        idle(3);
        check("t5_load_end", n_load_end - le0, 1);
        check("t5_count_cleared", record_count, 0);

        // Async reset mid-address
        send_str("W0000");
        comm_reset_n = 1'b0;
        #1;
        check("t6_in_ready", in_ready, 0);
        check("t6_valid", record_out_valid, 0);
        check("t6_record", record_out, 0);
        check("t6_flags", {load_end, parse_error, led}, 0);
        idle(2);
        comm_reset_n = 1'b1;
        idle(1);
        expect_rec(1'b0, 32'h00000010, 32'h00000020, 0);
        send_str("W00000010:00000020\n");
        idle(3);
        check("t6_count", record_count, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/computie_bus_loader.md
Name: computie_bus_loader

Overview:
- Receive side of the computie bus trace text format.
- Accepts an ASCII byte stream (serial RX) of lines `R<addr hex>:<data hex>\n` / `W...` and rebuilds packed bus records `{mode, addr, data}` with an index.
- Records go out on a valid/ready port for replay/stimulus buffers.
- Blank-line framing, as emitted by the trace dump, delimits a block.

Parameters:
- BITWIDTH, 32, address and data field width in bits; multiple of 4; digits per field = BITWIDTH/4.
- MODWIDTH, 1, mode field width; bit 0 = 1 for R, 0 for W; upper bits are always 0.
- DEPTH, 512, maximum records per block.

Ports:
- comm_clock  in  1  sole clock.
- comm_reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  ASCII byte.
- record_out_valid  out  1  record available.
- record_out_ready  in  1  consumer accepts record.
- record_out  out  BITWIDTH*2+MODWIDTH  {mode, addr, data}; addr in [BITWIDTH*2-1:BITWIDTH], data in [BITWIDTH-1:0].
- record_out_index  out  $clog2(DEPTH)+1  index of current record within block, 0-based.
- record_count  out  $clog2(DEPTH)+1  records emitted in current block.
- load_end  out  1  one-cycle pulse: block terminated by blank line.
- parse_error  out  1  one-cycle pulse on malformed line or overflow.
- led  out  1  toggles on each emitted record.

Behaviour:
- Reset values: in_ready=0, record_out_valid=0, record_out=0, record_out_index=0, record_count=0, load_end=0, parse_error=0, led=0, state=ST_LINE.
- Reset deasserted mid-line: the partial line is lost. in_ready rises on the first clock after reset release.
- A byte is taken when in_valid && in_ready.
- in_ready=1 in every state except ST_EMIT.
- '\r' is ignored in all states.
- ST_LINE:
  - 'R' or 'W' latches the mode, clears the digit count → ST_ADDR.
  - '\n' with record_count>0: pulse load_end, clear record_count and index. Otherwise '\n' is ignored (header line).
  - Any other byte → error.
- ST_ADDR:
  - Hex digit shifts into addr (MSB first); digit count +1.
  - ':' with count==BITWIDTH/4 → ST_DATA, count cleared.
  - Otherwise, or a (BITWIDTH/4+1)th digit → error.
- ST_DATA: same rules as ST_ADDR; terminator is '\n' → ST_EMIT.
- ST_EMIT:
  - If record_count==DEPTH: record dropped, error.
  - Else record_out_valid=1 on the cycle after the '\n' is accepted (latency 1).
  - record_out and record_out_index are held stable until record_out_ready.
  - On handshake: valid→0, record_count+1, index+1, led toggles → ST_LINE.
- Error path: pulse parse_error for one cycle → ST_SKIP. ST_SKIP discards bytes until '\n', then → ST_LINE.
  - A '\n' that itself causes the error (short data field) → ST_LINE directly.
  - A partial line never emits a record.
- Hex: '0'-'9' → 0-9, 'A'-'F' → 10-15, uppercase only unless the optional feature is enabled.
- Digit counter width is $clog2(BITWIDTH/4)+1, saturating.
- load_end and parse_error are never high in the same cycle.
- record_out_ready high while valid is low has no effect.

Optional Feature:
- COMPUTIE_BUS_LOADER_LOWERCASE_EN defined: 'a'-'f' are also accepted as hex 10-15.
- Undefined: lowercase hex is a parse error. This keeps the strict round-trip with the dump format.

Decomposition:
- Shared package/include computie_bus_pkg holds:
  - state encodings ST_LINE/ST_ADDR/ST_DATA/ST_EMIT/ST_SKIP;
  - ASCII constants (CH_R, CH_W, CH_COLON, CH_LF, CH_CR);
  - record field offset constants, reused by the dumper.
- One sub-module: computie_bus_hex_decode, combinational byte → {valid, nibble}. It honours the lowercase macro.

Test Plan:
- Stream "\nR00001234:DEADBEEF\nW0000ABCD:00000001\n\n" with ready=1 → two records:
  - {1,0x00001234,0xDEADBEEF} at index 0;
  - {0,0x0000ABCD,0x00000001} at index 1;
  - then load_end pulses once and record_count returns to 0.
- Same first line with record_out_ready held 0 for 10 cycles → valid and record stable, in_ready=0 throughout, no byte lost. Release → handshake, led toggles.
- "R0001234:DEADBEEF\n" (7 addr digits) → parse_error at ':', no record. The following valid line parses normally.
- "Rdeadbeef:00000000\n" → parse_error without the macro; with the macro, record addr=0xDEADBEEF.
- DEPTH=4, five valid lines → four records, parse_error on the fifth '\n'. Blank line → load_end, count cleared.
- Assert comm_reset_n low mid-ADDR → all outputs at reset values immediately. After release, "W00000010:00000020\n" emits index 0.
